// File: rtl/window_gen_3x3_pkg.sv
// 3x3 sliding-window generator: shared constants.
// Window taps are row-major, oldest pixel at tap 0.
package window_gen_3x3_pkg;

  localparam int DATA_W   = 8;
  localparam int WIN_ROWS = 3;
  localparam int WIN_COLS = 3;
  localparam int WIN_TAPS = WIN_ROWS * WIN_COLS;
  localparam int WIN_W    = WIN_TAPS * DATA_W;

  // Rk_Cm is the pixel at (r-k, c-m) relative to the newest pixel (r,c).
  localparam int TAP_R2_C2 = 0;
  localparam int TAP_R2_C1 = 1;
  localparam int TAP_R2_C0 = 2;
  localparam int TAP_R1_C2 = 3;
  localparam int TAP_R1_C1 = 4;
  localparam int TAP_R1_C0 = 5;
  localparam int TAP_R0_C2 = 6;
  localparam int TAP_R0_C1 = 7;
  localparam int TAP_R0_C0 = 8;

  // Row slot 0 is row r-2, column slot 0 is column c-2.
  function automatic int tap_idx(input int row_slot, input int col_slot);
    return row_slot * WIN_COLS + col_slot;
  endfunction

endpackage

// File: rtl/window_gen_3x3_if.sv
// 3x3 sliding-window generator: pixel-in / window-out bundle.
// master drives pixels, slave produces windows.
interface window_gen_3x3_if #(
  parameter int DATA_W = window_gen_3x3_pkg::DATA_W
) ();
  import window_gen_3x3_pkg::*;

  logic [DATA_W-1:0]          pix_in;
  logic                       pix_valid;
  logic                       sof;
  logic [WIN_TAPS*DATA_W-1:0] win_out;
  logic                       win_valid;
  logic                       win_last;

  modport master (
    output pix_in, pix_valid, sof,
    input  win_out, win_valid, win_last
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output win_out, win_valid, win_last
  );

endinterface

// File: rtl/window_gen_3x3_lb_ram_sdp.sv
// Two-row line buffer: simple dual-port RAM.
// Registered read, no reset on the array or read port.
module lb_ram_sdp #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and synchronous read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Emits only fully interior windows, two cycles after the pixel.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = window_gen_3x3_pkg::DATA_W
) (
  input logic             clk,
  input logic             reset,
  window_gen_3x3_if.slave bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int OW = WIN_TAPS * DATA_W;

  logic [CW-1:0] col_q, cur_col, s1_col;
  logic [RW-1:0] row_q, cur_row, s1_row;
  logic          s1_valid;
  logic [DATA_W-1:0] s1_pix;
  logic [2*DATA_W-1:0] lb_rd;
  logic          s2_valid, s2_ok, s2_end;
  logic [DATA_W-1:0] win_q [WIN_ROWS][WIN_COLS];
  logic [OW-1:0] win_packed;

  // Position of the pixel being accepted; sof forces (0,0).
  always_comb begin
    cur_col = bus.sof ? '0 : col_q;
    cur_row = bus.sof ? '0 : row_q;
  end

  // Raster counters advance only on accepted pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (bus.pix_valid) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col_q <= '0;
        row_q <= (cur_row == RW'(IMG_HEIGHT - 1))
               ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end
  end

  // Stage 1: hold the pixel while its line-buffer read returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      if (bus.pix_valid) begin
        s1_pix <= bus.pix_in;
        s1_col <= cur_col;
        s1_row <= cur_row;
      end
    end
  end

  // Word per column is {row r-2, row r-1}; write-back ages it by one row.
  lb_ram_sdp #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (2 * DATA_W)
  ) u_lb (
    .clk   (clk),
    .we    (s1_valid),
    .waddr (s1_col),
    .wdata ({lb_rd[DATA_W-1:0], s1_pix}),
    .re    (bus.pix_valid),
    .raddr (cur_col),
    .rdata (lb_rd)
  );

  // Stage 2: shift the new column into the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIN_ROWS; i++)
        for (int j = 0; j < WIN_COLS; j++)
          win_q[i][j] <= '0;
    end else if (s1_valid) begin
      for (int i = 0; i < WIN_ROWS; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= lb_rd[2*DATA_W-1:DATA_W];
      win_q[1][2] <= lb_rd[DATA_W-1:0];
      win_q[2][2] <= s1_pix;
    end
  end

  // Stage 2 control: interior and frame-end flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_ok    <= 1'b0;
      s2_end   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_ok    <= (s1_row >= RW'(2)) && (s1_col >= CW'(2));
      s2_end   <= (s1_row == RW'(IMG_HEIGHT - 1))
               && (s1_col == CW'(IMG_WIDTH - 1));
    end
  end

  // Flatten the window, oldest tap in the low bits.
  always_comb begin
    win_packed = '0;
    for (int i = 0; i < WIN_ROWS; i++)
      for (int j = 0; j < WIN_COLS; j++)
        win_packed[tap_idx(i, j)*DATA_W +: DATA_W] = win_q[i][j];
  end

  // Output stage: register window; hold it between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.win_out   <= '0;
      bus.win_valid <= 1'b0;
      bus.win_last  <= 1'b0;
    end else begin
      bus.win_valid <= s2_valid && s2_ok;
      bus.win_last  <= s2_valid && s2_ok && s2_end;
      if (s2_valid && s2_ok) bus.win_out <= win_packed;
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: frame-array reference model,
// scoreboard queue and a negedge monitor.
module tb_window_gen_3x3;
  import window_gen_3x3_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  window_gen_3x3_if #(.DATA_W(DATA_W)) bus ();

  window_gen_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_W     (DATA_W)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [WIN_W-1:0] win;
    logic             last;
    int               cyc;
  } exp_t;

  exp_t             exp_q [$];
  logic [WIN_W-1:0] got_win [$];
  logic             got_last [$];
  logic [WIN_W-1:0] ref_a [$];
  logic [7:0]       img [H][W];
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int mr     = 0;
  int mc     = 0;

  task automatic chk(input string nm, input logic [WIN_W-1:0] got,
                     input logic [WIN_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  // Reference model: frame image array, raster position, window rule.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      mr = 0;
      mc = 0;
      exp_q.delete();
    end else begin
      cyc++;
      if (bus.pix_valid) begin
        if (bus.sof) begin
          mr = 0;
          mc = 0;
        end
        img[mr][mc] = bus.pix_in;
        if (mr >= 2 && mc >= 2) begin
          e.win = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.win[(i*3+j)*8 +: 8] = img[mr-2+i][mc-2+j];
          e.last = (mr == H-1) && (mc == W-1);
          e.cyc  = cyc + 2;
          exp_q.push_back(e);
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr + 1) % H;
        end
      end
    end
  end

  // Monitor: pop and compare on every window pulse.
  logic [WIN_W-1:0] last_out = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_out = '0;
    end else if (bus.win_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_win got=%h exp=none", bus.win_out);
      end else begin
        e = exp_q.pop_front();
        chk("win_out", bus.win_out, e.win);
        chk("win_last", bus.win_last, e.last);
        chk("win_cycle", cyc, e.cyc);
      end
      got_win.push_back(bus.win_out);
      got_last.push_back(bus.win_last);
      last_out = bus.win_out;
    end else begin
      chk("hold", bus.win_out, last_out);
      chk("last_idle", bus.win_last, 0);
    end
  end

  task automatic pix(input logic [7:0] v, input logic s);
    @(negedge clk);
    bus.pix_in    = v;
    bus.sof       = s;
    bus.pix_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.sof       = 1'($urandom_range(0, 1));
    bus.pix_in    = 8'($urandom);
  endtask

  task automatic drain();
    repeat (6) idle();
  endtask

  task automatic clear_log();
    got_win.delete();
    got_last.delete();
  endtask

  // rnd: random pixel values; gapm 0 none, 1 one-in-three, 2 random.
  task automatic send_frame(input bit rnd, input int base,
                            input bit use_sof, input int gapm);
    int g;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        g = (gapm == 1) ? 2 :
            (gapm == 2 && $urandom_range(0, 1) == 1)
            ? int'($urandom_range(1, 3)) : 0;
        repeat (g) idle();
        if (rnd) pix(8'($urandom), use_sof && r == 0 && c == 0);
        else pix(8'(base + r*16 + c), use_sof && r == 0 && c == 0);
      end
    end
  endtask

  task automatic reset_check(input string nm);
    chk({nm, "_win_out"}, bus.win_out, 0);
    chk({nm, "_win_valid"}, bus.win_valid, 0);
    chk({nm, "_win_last"}, bus.win_last, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    int same;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.pix_in    = '0;
    #3 rst = 1'b1;
    #1 reset_check("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Continuous frame, values row*16+col.
    clear_log();
    send_frame(0, 0, 1, 0);
    drain();
    chk("a_count", got_win.size(), 24);
    chk("a_first", got_win[0], 72'h22_21_20_12_11_10_02_01_00);
    chk("a_row3", got_win[6], 72'h32_31_30_22_21_20_12_11_10);
    chk("a_final", got_win[23], 72'h57_56_55_47_46_45_37_36_35);
    chk("a_final_last", got_last[23], 1);
    nl = 0;
    foreach (got_last[i]) if (got_last[i]) nl++;
    chk("a_last_count", nl, 1);
    ref_a = got_win;

    // Same frame, pixel accepted one cycle in three.
    clear_log();
    send_frame(0, 0, 1, 1);
    drain();
    chk("b_count", got_win.size(), 24);
    same = (got_win.size() == ref_a.size()) ? 1 : 0;
    foreach (got_win[i])
      if (i < ref_a.size() && got_win[i] !== ref_a[i]) same = 0;
    chk("b_same_seq", same, 1);

    // Reset while pixel 0x34 is being accepted.
    clear_log();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c <= 4) pix(8'(r*16 + c), r == 0 && c == 0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.pix_valid = 1'b0;
    #1 reset_check("mid");
    chk("mid_pre_count", got_win.size(), 6);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
    send_frame(0, 8'h40, 0, 2);
    drain();
    chk("r_count", got_win.size(), 24);
    chk("r_first", got_win[0], 72'h62_61_60_52_51_50_42_41_40);

    // sof reasserted where old pixel 0x25 would be.
    clear_log();
    for (int c = 0; c < W; c++) pix(8'(c), c == 0);
    for (int c = 0; c < W; c++) pix(8'(16 + c), 0);
    for (int c = 0; c < 5; c++) pix(8'(32 + c), 0);
    send_frame(0, 8'h80, 1, 0);
    drain();
    chk("s_count", got_win.size(), 27);
    chk("s_old_0x24", got_win[2][71:64], 8'h24);
    chk("s_new_first", got_win[3], 72'hA2_A1_A0_92_91_90_82_81_80);

    // Random frames with random stalls.
    repeat (3) begin
      clear_log();
      send_frame(1, 0, 1, 2);
      drain();
      chk("rnd_count", got_win.size(), 24);
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per row; SHALL be at least 4.
REQ-002 Parameter IMG_HEIGHT, default 480, rows per frame; SHALL be at least 3.
REQ-003 Parameter DATA_W, default 8, unsigned pixel width.
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pix_in  input  DATA_W  raster-order pixel.
REQ-007 pix_valid  input  1  pix_in (and sof) accepted on a rising edge where high.
REQ-008 sof  input  1  start of frame: the accepted pixel is (row 0, col 0).
REQ-009 win_out  output  9*DATA_W  3x3 window for the downstream conv stage.
REQ-010 win_valid  output  1  win_out holds a complete window this cycle.
REQ-011 win_last  output  1  window is the final one of the frame.

Function
REQ-012 Internal col/row counters SHALL advance only on accepted pixels: col wraps IMG_WIDTH-1 -> 0 with row+1; row wraps IMG_HEIGHT-1 -> 0.
REQ-013 An accepted pixel with sof=1 SHALL be taken as (0,0), with counters advancing from there; sof with pix_valid=0 SHALL be ignored.
REQ-014 win_out packing SHALL be: bits [7:0] = (r-2,c-2), [15:8] = (r-2,c-1), [23:16] = (r-2,c), [31:24] = (r-1,c-2) ... [71:64] = (r,c), where (r,c) is the newest pixel.
REQ-015 Pipeline: edge N accepts the pixel and issues the line-buffer read at col. Edge N+1 returns the read data, writes back, and shifts the window. Edge N+2 registers win_out and win_valid.
REQ-016 win_valid SHALL pulse for exactly one cycle, 2 cycles after the accepting edge, and only when r>=2 and c>=2 (valid convolution only, no padding).
REQ-017 The window count per frame SHALL be (IMG_HEIGHT-2)*(IMG_WIDTH-2).
REQ-018 win_last SHALL equal win_valid for r=IMG_HEIGHT-1, c=IMG_WIDTH-1; otherwise 0.
REQ-019 Gaps in pix_valid SHALL be allowed at any point, including back-to-back and arbitrary stalls.
REQ-020 The pipeline SHALL carry a valid bit per stage and SHALL produce no output for bubbles.
REQ-021 The line buffer SHALL hold two rows as one DATA_W*2 word per column: {row r-2, row r-1}.
REQ-022 On each accepted pixel, the line buffer at address col SHALL be read, then overwritten one cycle later with {read row r-1, pix_in}.
REQ-023 The line buffer read SHALL be registered (M10k synchronous read).
REQ-024 Back-to-back pixels SHALL never read and write the same address in one cycle; the IMG_WIDTH>=4 parameter constraint guarantees this.
REQ-025 Window columns left over from the previous row at c=0/1 SHALL NOT be exported; win_valid suppression covers them.
REQ-026 sof mid-frame: in-flight pixels SHALL complete with their old coordinates; the line buffer SHALL NOT be cleared; the first new window SHALL be (2,2).
REQ-027 win_out SHALL hold its last value while win_valid=0.

Reset
REQ-028 reset SHALL asynchronously clear the counters, pipeline valid bits, window registers, win_out (0), win_valid (0), and win_last (0).
REQ-029 Line-buffer RAM contents SHALL NOT be reset; rows 0/1 after reset overwrite them before any window is emitted.
REQ-030 reset mid-frame SHALL drop in-flight pixels; the counters restart at (0,0) with or without sof.

Structure
REQ-031 A shared package SHALL hold DATA_W, WIN_TAPS=9, WIN_W=72, and the tap-index constants for REQ-014 packing.
REQ-032 One sub-module lb_ram_sdp SHALL implement the simple dual-port RAM: IMG_WIDTH x 2*DATA_W, registered read, write-enable.
REQ-033 The target RTL size is 150-250 lines.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, pixel value = row*16+col)
REQ-034 Continuous frame with sof at (0,0): the first win_valid is 2 cycles after pixel 0x22, with win_out = 0x22_21_20_12_11_10_02_01_00 (MSB..LSB); there are exactly 24 windows.
REQ-035 Row boundary: pixels 0x30, 0x31 produce no win_valid; pixel 0x32 gives win_out = 0x32_31_30_22_21_20_12_11_10.
REQ-036 pix_valid high one cycle in three: the window sequence is identical to REQ-034, each window 2 cycles after its pixel, and there are no duplicate pulses.
REQ-037 Final window 0x57_56_55_47_46_45_37_36_35 has win_last=1; all other windows have win_last=0.
REQ-038 reset asserted at pixel 0x34: outputs go to 0 asynchronously, no window is emitted for 0x34; a new frame then yields its first window at (2,2) with correct values.
REQ-039 sof reasserted at old pixel 0x25: the windows for 0x23/0x24 still emit normally; no window appears until new (2,2), and that window holds the new-frame values.
